memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_pkg.sv | 45 ++++
 rtl/memory_stage_if.sv | 48 ++++
 rtl/memory_stage.sv | 158 +++++++++++++++
 tb/tb_memory_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared Y86-64 definitions: icodes, register ids, ALU/condition codes,
// status codes and memory-stage types.
package memory_stage_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;

  localparam logic [3:0] C_YES    = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_RESP,
    S_HALTED
  } state_e;

endpackage

// File: rtl/memory_stage_if.sv
// Execute-in, writeback-out and data-memory bus of the memory stage.
interface memory_stage_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  icode_i;
  logic [63:0] valE_i;
  logic [63:0] valA_i;
  logic [63:0] valP_i;
  logic        cnd_i;
  logic [3:0]  dstE_i;
  logic [3:0]  dstM_i;

  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  icode_o;
  logic [63:0] valE_o;
  logic [63:0] valM_o;
  logic        cnd_o;
  logic [3:0]  dstE_o;
  logic [3:0]  dstM_o;
  logic [2:0]  stat_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [63:0] mem_rdata_i;
  logic        mem_err_i;

  modport slave (
    input  in_valid_i, icode_i, valE_i, valA_i, valP_i,
    input  cnd_i, dstE_i, dstM_i, out_ready_i,
    input  mem_ack_i, mem_rdata_i, mem_err_i,
    output in_ready_o, out_valid_o, icode_o, valE_o, valM_o,
    output cnd_o, dstE_o, dstM_o, stat_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output in_valid_i, icode_i, valE_i, valA_i, valP_i,
    output cnd_i, dstE_i, dstM_i, out_ready_i,
    output mem_ack_i, mem_rdata_i, mem_err_i,
    input  in_ready_o, out_valid_o, icode_o, valE_o, valM_o,
    input  cnd_o, dstE_o, dstM_o, stat_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 memory stage: one op in flight, optional data-memory access,
// sticky HALTED on any non-AOK status.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter logic [63:0] MEM_BYTES = 64'h2000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  memory_stage_if.slave  bus
);

  localparam logic [63:0] ADDR_MAX = MEM_BYTES - 64'd8;

  state_e      state_q, state_d;
  logic [3:0]  icode_q, icode_d;
  logic [63:0] valE_q, valE_d;
  logic [63:0] valM_q, valM_d;
  logic        cnd_q, cnd_d;
  logic [3:0]  dstE_q, dstE_d;
  logic [3:0]  dstM_q, dstM_d;
  logic [2:0]  stat_q, stat_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;

  logic        dec_mem;
  logic        dec_we;
  logic [63:0] dec_addr;
  logic [63:0] dec_wdata;
  logic [2:0]  dec_stat;

  always_comb begin
    dec_mem   = 1'b0;
    dec_we    = 1'b0;
    dec_addr  = bus.valE_i;
    dec_wdata = bus.valA_i;
    unique case (1'b1)
      (bus.icode_i == I_RMMOVQ),
      (bus.icode_i == I_PUSHQ): begin
        dec_mem = 1'b1;
        dec_we  = 1'b1;
      end
      (bus.icode_i == I_CALL): begin
        dec_mem   = 1'b1;
        dec_we    = 1'b1;
        dec_wdata = bus.valP_i;
      end
      (bus.icode_i == I_MRMOVQ): begin
        dec_mem = 1'b1;
      end
      (bus.icode_i == I_POPQ),
      (bus.icode_i == I_RET): begin
        dec_mem  = 1'b1;
        dec_addr = bus.valA_i;
      end
      default: ;
    endcase
    unique case (1'b1)
      (bus.icode_i == I_HALT): dec_stat = STAT_HLT;
      (bus.icode_i > I_POPQ):  dec_stat = STAT_INS;
      default:                 dec_stat = STAT_AOK;
    endcase
  end

  always_comb begin
    state_d = state_q;
    icode_d = icode_q;
    valE_d  = valE_q;
    valM_d  = valM_q;
    cnd_d   = cnd_q;
    dstE_d  = dstE_q;
    dstM_d  = dstM_q;
    stat_d  = stat_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid_i) begin
          icode_d = bus.icode_i;
          valE_d  = bus.valE_i;
          valM_d  = '0;
          cnd_d   = bus.cnd_i;
          dstE_d  = bus.dstE_i;
          dstM_d  = bus.dstM_i;
          stat_d  = dec_stat;
          we_d    = dec_we;
          addr_d  = dec_addr;
          wdata_d = dec_wdata;
          state_d = S_RESP;
          // Out-of-range accesses never reach the memory bus.
          if (dec_mem) begin
            if (dec_addr > ADDR_MAX) stat_d = STAT_ADR;
            else                     state_d = S_MEM;
          end
        end
      end
      S_MEM: begin
        if (bus.mem_ack_i) begin
          state_d = S_RESP;
          if (bus.mem_err_i)  stat_d = STAT_ADR;
          else if (!we_q)     valM_d = bus.mem_rdata_i;
        end
      end
      S_RESP: begin
        if (bus.out_ready_i) begin
          state_d = (stat_q == STAT_AOK) ? S_IDLE : S_HALTED;
        end
      end
      S_HALTED: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      icode_q <= '0;
      valE_q  <= '0;
      valM_q  <= '0;
      cnd_q   <= 1'b0;
      dstE_q  <= '0;
      dstM_q  <= '0;
      stat_q  <= STAT_AOK;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      icode_q <= icode_d;
      valE_q  <= valE_d;
      valM_q  <= valM_d;
      cnd_q   <= cnd_d;
      dstE_q  <= dstE_d;
      dstM_q  <= dstM_d;
      stat_q  <= stat_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.in_ready_o  = (state_q == S_IDLE);
  assign bus.out_valid_o = (state_q == S_RESP);
  assign bus.mem_req_o   = (state_q == S_MEM);
  assign bus.mem_we_o    = (state_q == S_MEM) && we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.icode_o     = icode_q;
  assign bus.valE_o      = valE_q;
  assign bus.valM_o      = valM_q;
  assign bus.cnd_o       = cnd_q;
  assign bus.dstE_o      = dstE_q;
  assign bus.dstM_o      = dstM_q;
  assign bus.stat_o      = stat_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: scoreboard of expected writeback
// results, inline memory responder, halt and reset scenarios.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam logic [63:0] MB = 64'h2000;

  typedef struct packed {
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        cnd;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [2:0]  stat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_stage_if bus();

  memory_stage #(.MEM_BYTES(MB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   req_cnt = 0;
  int   r0;

  always @(posedge clk) if (bus.mem_req_o === 1'b1) req_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid_i  = 1'b0;
    bus.icode_i     = I_NOP;
    bus.valE_i      = '0;
    bus.valA_i      = '0;
    bus.valP_i      = '0;
    bus.cnd_i       = 1'b0;
    bus.dstE_i      = R_NONE;
    bus.dstM_i      = R_NONE;
    bus.out_ready_i = 1'b0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    bus.mem_err_i   = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready_o), 64'd1);
    chk({tag, "_out_valid"}, 64'(bus.out_valid_o), 64'd0);
    chk({tag, "_mem_req"}, 64'(bus.mem_req_o), 64'd0);
  endtask

  task automatic send(input logic [3:0] icode, input logic [63:0] valE,
                      input logic [63:0] valA, input logic [63:0] valP,
                      input logic cnd, input logic [3:0] dstE,
                      input logic [3:0] dstM, input logic [63:0] exp_valM,
                      input logic [2:0] exp_stat);
    int n = 0;
    bus.in_valid_i = 1'b1;
    bus.icode_i = icode;
    bus.valE_i  = valE;
    bus.valA_i  = valA;
    bus.valP_i  = valP;
    bus.cnd_i   = cnd;
    bus.dstE_i  = dstE;
    bus.dstM_i  = dstM;
    while (bus.in_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 64'(bus.in_ready_o), 64'd1);
    sb.push_back('{icode, valE, exp_valM, cnd, dstE, dstM, exp_stat});
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic mem_serve(input logic we, input logic [63:0] addr,
                           input logic [63:0] wdata, input int n,
                           input logic [63:0] rdata, input logic err);
    for (int i = 0; i < n; i++) begin
      chk("mem_req", 64'(bus.mem_req_o), 64'd1);
      chk("mem_we", 64'(bus.mem_we_o), 64'(we));
      chk("mem_addr", bus.mem_addr_o, addr);
      if (we) chk("mem_wdata", bus.mem_wdata_o, wdata);
      chk("mem_no_out_valid", 64'(bus.out_valid_o), 64'd0);
      if (i == n - 1) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = rdata;
        bus.mem_err_i   = err;
      end
      @(negedge clk);
    end
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    bus.mem_err_i   = 1'b0;
    chk("mem_req_drop", 64'(bus.mem_req_o), 64'd0);
  endtask

  task automatic wait_out(input int exp_lat, input int hold);
    exp_t e;
    int lat = 0;
    while (bus.out_valid_o !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("out_latency", 64'(lat), 64'(exp_lat));
    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      chk("out_valid", 64'(bus.out_valid_o), 64'd1);
      chk("out_in_ready", 64'(bus.in_ready_o), 64'd0);
      chk("icode_o", 64'(bus.icode_o), 64'(e.icode));
      chk("valE_o", bus.valE_o, e.valE);
      chk("valM_o", bus.valM_o, e.valM);
      chk("cnd_o", 64'(bus.cnd_o), 64'(e.cnd));
      chk("dstE_o", 64'(bus.dstE_o), 64'(e.dstE));
      chk("dstM_o", 64'(bus.dstM_o), 64'(e.dstM));
      chk("stat_o", 64'(bus.stat_o), 64'(e.stat));
      if (h == hold) bus.out_ready_i = 1'b1;
      @(negedge clk);
    end
    bus.out_ready_i = 1'b0;
  endtask

  task automatic check_halted();
    bus.in_valid_i = 1'b1;
    bus.icode_i    = I_OPQ;
    bus.mem_ack_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("halt_in_ready", 64'(bus.in_ready_o), 64'd0);
      chk("halt_out_valid", 64'(bus.out_valid_o), 64'd0);
      chk("halt_mem_req", 64'(bus.mem_req_o), 64'd0);
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk_idle("rst");
    chk("rst_stat", 64'(bus.stat_o), 64'(STAT_AOK));
    chk("rst_valE", bus.valE_o, 64'd0);
    chk("rst_valM", bus.valM_o, 64'd0);
    chk("rst_we", 64'(bus.mem_we_o), 64'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    do_reset();
    chk("rst_icode", 64'(bus.icode_o), 64'd0);

    r0 = req_cnt;
    send(I_OPQ, 64'd5, 64'd2, 64'd10, 1'b1, 4'd3, R_NONE, 64'd0, STAT_AOK);
    wait_out(0, 0);
    chk("opq_no_req", 64'(req_cnt), 64'(r0));
    chk_idle("opq_after");

    send(I_MRMOVQ, 64'h100, 64'h11, 64'h20, 1'b0, R_NONE, 4'd4,
         64'hDEAD, STAT_AOK);
    mem_serve(1'b0, 64'h100, 64'd0, 3, 64'hDEAD, 1'b0);
    wait_out(0, 0);

    send(I_PUSHQ, 64'h1F8, 64'd7, 64'h30, 1'b1, 4'd4, R_NONE,
         64'd0, STAT_AOK);
    mem_serve(1'b1, 64'h1F8, 64'd7, 1, 64'hBAD0, 1'b0);
    wait_out(0, 4);

    send(I_CALL, 64'h200, 64'h99, 64'h40, 1'b0, 4'd4, R_NONE,
         64'd0, STAT_AOK);
    mem_serve(1'b1, 64'h200, 64'h40, 2, 64'h1111, 1'b0);
    wait_out(0, 0);

    send(I_POPQ, 64'h308, 64'h300, 64'h50, 1'b0, 4'd4, 4'd3,
         64'h1234, STAT_AOK);
    mem_serve(1'b0, 64'h300, 64'd0, 1, 64'h1234, 1'b0);
    wait_out(0, 1);

    send(I_RET, 64'h310, 64'h308, 64'h60, 1'b1, 4'd4, R_NONE,
         64'h777, STAT_AOK);
    mem_serve(1'b0, 64'h308, 64'd0, 2, 64'h777, 1'b0);
    wait_out(0, 0);

    send(I_RMMOVQ, MB - 64'd8, 64'hAB, 64'h70, 1'b0, R_NONE, R_NONE,
         64'd0, STAT_AOK);
    mem_serve(1'b1, MB - 64'd8, 64'hAB, 1, 64'd0, 1'b0);
    wait_out(0, 0);

    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 64'h5A5A;
    @(negedge clk);
    idle_inputs();
    chk_idle("stray_ack");
    chk("stray_ack_valM", bus.valM_o, 64'd0);

    r0 = req_cnt;
    send(I_RMMOVQ, MB - 64'd7, 64'hCD, 64'h80, 1'b0, R_NONE, R_NONE,
         64'd0, STAT_ADR);
    wait_out(0, 0);
    chk("oob_no_req", 64'(req_cnt), 64'(r0));
    check_halted();
    do_reset();

    send(I_MRMOVQ, 64'h40, 64'd0, 64'h90, 1'b0, R_NONE, 4'd2,
         64'd0, STAT_ADR);
    mem_serve(1'b0, 64'h40, 64'd0, 2, 64'hFFFF, 1'b1);
    wait_out(0, 0);
    check_halted();
    do_reset();

    send(I_HALT, 64'd0, 64'd0, 64'h1, 1'b0, R_NONE, R_NONE,
         64'd0, STAT_HLT);
    wait_out(0, 0);
    check_halted();
    do_reset();

    send(4'hC, 64'h3, 64'h4, 64'h2, 1'b1, 4'd1, 4'd2, 64'd0, STAT_INS);
    wait_out(0, 0);
    check_halted();
    do_reset();

    send(I_MRMOVQ, 64'h80, 64'd0, 64'hA0, 1'b0, R_NONE, 4'd5,
         64'd0, STAT_AOK);
    chk("rstmem_req", 64'(bus.mem_req_o), 64'd1);
    do_reset();
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 64'h5555;
    @(negedge clk);
    idle_inputs();
    chk_idle("late_ack");
    chk("late_ack_valM", bus.valM_o, 64'd0);

    send(I_OPQ, 64'd9, 64'd1, 64'hB0, 1'b1, 4'd6, R_NONE, 64'd0, STAT_AOK);
    wait_out(0, 0);
    chk_idle("final");
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
